glyph_blit_ctrl: RTL
====================

Name: glyph_blit_ctrl

Overview:
Sequencer that copies one 8x16 digit glyph from the 1-bit glyph ROM bank into the frame buffer at a given screen position. On a start pulse it walks ROM addresses 0..127 (address = row*8 + col) and waits out the 1-cycle registered ROM read. It then emits one pixel write per address over a valid/ready handshake to the frame-buffer writer. It sits between the display-update logic (score/clock digits) and the shared frame-buffer write port.

Parameters:
X_W, 10, width of screen x coordinate
Y_W, 9, width of screen y coordinate
PIX_W, 8, frame-buffer pixel width
FG, 8'hFF, pixel value written for glyph bit 1
BG, 8'h00, pixel value written for glyph bit 0

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to blit; sampled only in IDLE
digit  in  4  glyph index 0..9, captured on accepted start
dst_x  in  X_W  top-left x, captured on accepted start
dst_y  in  Y_W  top-left y, captured on accepted start
busy  out  1  high from accepted start through DONE
done  out  1  one-cycle pulse after last pixel accepted
rom_sel  out  4  glyph ROM select (captured digit)
rom_addr  out  7  glyph ROM address
rom_q  in  1  muxed ROM data, valid 1 cycle after rom_addr changes
fb_valid  out  1  pixel write request
fb_ready  in  1  frame-buffer writer accepts when valid&ready
fb_x  out  X_W  pixel x = dst_x + col, modulo 2^X_W
fb_y  out  Y_W  pixel y = dst_y + row, modulo 2^Y_W
fb_data  out  PIX_W  FG or BG

Behaviour:
- Reset (async, reset_n low): state IDLE, idx=0, busy=0, done=0, fb_valid=0, rom_addr=0, rom_sel=0, fb_x=0, fb_y=0, fb_data=BG. Reset mid-blit abandons it; no further writes.
- rom_addr is always the registered idx; col = idx[2:0], row = idx[6:3].
- States: IDLE, FETCH, EMIT, DONE.
- IDLE: start=1 -> capture digit/dst_x/dst_y, idx=0, busy=1, go FETCH. start=0 -> stay.
- FETCH: one cycle for the ROM read of rom_addr; then EMIT.
- EMIT: fb_valid=1. fb_data=FG if rom_q=1 and digit<=9, else BG. fb_x/fb_y from the current idx. rom_addr is held, so rom_q stays stable while stalled.
  - fb_ready=0: hold all fb_* outputs unchanged.
  - fb_ready=1 and idx<127: idx++, go FETCH.
  - fb_ready=1 and idx==127: go DONE.
- DONE: done=1 for one cycle, busy still 1; next cycle IDLE, busy=0.
- Throughput: 2 cycles per pixel with fb_ready held high. Start to done = 1 + 128*2 + 1 = 258 cycles.
- start while busy is ignored; no queueing.
- digit 10..15: rom_sel still driven; every pixel is BG (blank glyph).
- Coordinate add truncates, so a glyph placed near the screen edge wraps around.

Optional Feature:
GLYPH_TRANSPARENT_EN
- Defined: in EMIT, when the pixel would be BG, fb_valid stays 0 and the block advances as if accepted (FETCH, or DONE at idx 127). Only FG pixels are written. Blank digits produce no writes; done still pulses.
- Undefined: all 128 pixels are written, as described above.

Decomposition:
- Shared package glyph_pkg: GLYPH_W=8, GLYPH_H=16, GLYPH_N=128, GLYPH_AW=7, DIGIT_MAX=9, and the state enum {IDLE, FETCH, EMIT, DONE}. The ROM bank mux and display-update logic reuse these.
- No sub-module. Counter and FSM are small; the ROM bank mux stays outside this block.

Test Plan:
- Reset mid-EMIT (idx=40) -> all outputs at reset values immediately; after release, block idles with no fb_valid.
- start, digit=7, dst=(100,50), fb_ready=1 -> 128 writes:
  - idx 25 gives (101,53) FG; idx 24 gives (100,53) BG; idx 127 gives (107,65) BG.
  - done pulses at cycle 258.
- Same blit with fb_ready toggling 1/0 -> fb_x/fb_y/fb_data stable while stalled; still exactly 128 accepted writes in order.
- start held high during blit and in the done cycle -> only one blit runs; a new one starts only after busy falls.
- digit=12, dst=(1020,0) -> all writes BG; x wraps, giving col 4 at fb_x=0.
- GLYPH_TRANSPARENT_EN with digit=7 -> writes only for set ROM bits (idx 25..30 first); digit=12 -> zero writes, done pulses.

Source files
------------

// File: rtl/glyph_pkg.sv
// -----------------------------------------------------------------------------
// glyph_pkg
// Shared constants for the 8x16 digit glyph path: glyph geometry, the ROM
// address width, the highest digit that has a real glyph, and the blit
// sequencer state encoding. The ROM bank mux and the display-update logic
// import this package as well.
// -----------------------------------------------------------------------------
package glyph_pkg;

    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int GLYPH_N  = GLYPH_W * GLYPH_H;
    localparam int GLYPH_AW = 7;

    // ROM address split: address = row*GLYPH_W + col
    localparam int COL_W = 3;
    localparam int ROW_W = 4;

    // Digits above this index have no glyph and render blank.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Index of the last pixel in a glyph.
    localparam logic [GLYPH_AW-1:0] IDX_LAST = 7'd127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } glyph_state_e;

endpackage

// File: rtl/glyph_blit_ctrl.sv
// -----------------------------------------------------------------------------
// glyph_blit_ctrl
// Copies one 8x16 digit glyph from the 1-bit glyph ROM bank into the frame
// buffer at (dst_x, dst_y). A start pulse in IDLE captures the request; the
// block then alternates FETCH (one cycle for the registered ROM read) and
// EMIT (offer one pixel write) for ROM addresses 0..127, and pulses done.
//
// Optional build macro: GLYPH_TRANSPARENT_EN
//   When defined, background pixels are skipped (no write is offered) and
//   only foreground pixels reach the frame buffer.
//
// Ports:
//   clock, reset_n      clock (posedge) and asynchronous active-low reset
//   start               one-cycle blit request, only looked at in IDLE
//   digit, dst_x, dst_y glyph index and top-left position, captured on start
//   busy                high from accepted start through the DONE cycle
//   done                one-cycle pulse after the last pixel is retired
//   rom_sel, rom_addr   glyph ROM select (captured digit) and address
//   rom_q               ROM data, valid one cycle after rom_addr changes
//   fb_valid, fb_ready  pixel write handshake
//   fb_x, fb_y, fb_data pixel position and value
//   dbg_state           current sequencer state (glyph_state_e encoding)
//
// Handshake: a pixel write transfers on a rising clock edge where both
// fb_valid and fb_ready are high. While fb_valid is high and fb_ready is low,
// fb_x, fb_y and fb_data hold their values, and fb_valid stays high until the
// transfer happens. fb_valid does not depend on fb_ready.
// -----------------------------------------------------------------------------
module glyph_blit_ctrl
    import glyph_pkg::*;
#(
    parameter int              X_W   = 10,
    parameter int              Y_W   = 9,
    parameter int              PIX_W = 8,
    parameter logic [PIX_W-1:0] FG   = 8'hFF,
    parameter logic [PIX_W-1:0] BG   = 8'h00
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          digit,
    input  logic [X_W-1:0]      dst_x,
    input  logic [Y_W-1:0]      dst_y,
    output logic                busy,
    output logic                done,
    output logic [3:0]          rom_sel,
    output logic [GLYPH_AW-1:0] rom_addr,
    input  logic                rom_q,
    output logic                fb_valid,
    input  logic                fb_ready,
    output logic [X_W-1:0]      fb_x,
    output logic [Y_W-1:0]      fb_y,
    output logic [PIX_W-1:0]    fb_data,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_EMIT  = EMIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]          state;
    logic [GLYPH_AW-1:0] idx;
    logic [3:0]          digit_r;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;

    logic pix_fg;      // current pixel is foreground
    logic pix_emit;    // a write is being offered this cycle
    logic pix_retire;  // current pixel is finished this cycle

    // rom_q is stable through a stall because rom_addr only moves on retire.
    assign pix_fg = rom_q && (digit_r <= DIGIT_MAX);

`ifdef GLYPH_TRANSPARENT_EN
    // Background pixels are dropped: no write offered, retired immediately.
    assign pix_emit   = (state == S_EMIT) && pix_fg;
    assign pix_retire = (state == S_EMIT) && (!pix_fg || fb_ready);
`else
    assign pix_emit   = (state == S_EMIT);
    assign pix_retire = pix_emit && fb_ready;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            digit_r <= '0;
            x_r     <= '0;
            y_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        digit_r <= digit;
                        x_r     <= dst_x;
                        y_r     <= dst_y;
                        idx     <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (pix_retire) begin
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 7'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;
    assign rom_sel   = digit_r;
    assign rom_addr  = idx;

    // Coordinate adds wrap at the register width, so a glyph near the right
    // or bottom edge continues at column/row 0.
    assign fb_x     = x_r + {{(X_W-COL_W){1'b0}}, idx[COL_W-1:0]};
    assign fb_y     = y_r + {{(Y_W-ROW_W){1'b0}}, idx[GLYPH_AW-1:COL_W]};
    assign fb_valid = pix_emit;
    assign fb_data  = (pix_emit && pix_fg) ? FG : BG;

endmodule
